// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one bit per cycle,
// radix-2 shift-add multiply and restoring divide, sign fix-up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    // state  | meaning
    // S_IDLE | accepting requests and direct HI/LO writes
    // S_CALC | WIDTH shift-add / shift-subtract iterations
    // S_FIX  | sign correction and HI/LO write-back
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opb_q, opb_d;
    logic [WIDTH-1:0]       a_raw_q, a_raw_d;
    logic                   is_div_q, is_div_d;
    logic                   neg_q, neg_d;
    logic                   rem_neg_q, rem_neg_d;
    logic                   dz_q, dz_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   div_zero_q, div_zero_d;

    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         add_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         rem_shift;
    logic [WIDTH-1:0]       rem_sub;
    logic                   rem_ge;
    logic [2*WIDTH-1:0]     div_next;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quot_fix, rem_fix;

    always_comb begin
        a_neg = op_i[0] & a_i[WIDTH-1];
        b_neg = op_i[0] & b_i[WIDTH-1];
        a_mag = a_neg ? ('0 - a_i) : a_i;
        b_mag = b_neg ? ('0 - b_i) : b_i;

        // Multiply: acc holds {partial product, remaining multiplier bits}
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {add_sum, acc_q[WIDTH-1:1]};

        // Divide: acc holds {partial remainder, dividend/quotient bits}
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        rem_ge    = rem_shift >= {1'b0, opb_q};
        rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
        div_next  = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};

        prod_fix = neg_q     ? ('0 - acc_q) : acc_q;
        quot_fix = neg_q     ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        a_raw_d    = a_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we_i) hi_d = wdata_i;
                if (lo_we_i) lo_d = wdata_i;
                if (req_i && !flush_i) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    is_div_d  = op_i[1];
                    a_raw_d   = a_i;
                    dz_d      = op_i[1] && (b_i == '0);
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    opb_d     = op_i[1] ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        // Divide by zero reports the untouched dividend, not its magnitude
                        hi_d       = a_raw_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            a_raw_q    <= a_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign ready_o    = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign div_zero_o = div_zero_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule
